// File: rtl/maple_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maple_responder_if : byte-level links between the PHY pair and responder  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface maple_responder_if;
  logic       rx_busy;
  logic       rx_write;
  logic [7:0] rx_data;
  logic       tx_enable;
  logic       tx_busy;
  logic       tx_next;
  logic [7:0] tx_data;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] last_cmd;

  modport slave (
    input  rx_busy, rx_write, rx_data, tx_busy, tx_next,
    output tx_enable, tx_data, frame_ok, frame_err, last_cmd
  );

  modport master (
    output rx_busy, rx_write, rx_data, tx_busy, tx_next,
    input  tx_enable, tx_data, frame_ok, frame_err, last_cmd
  );
endinterface
`default_nettype wire

// File: rtl/maple_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maple_responder : Maple peripheral frame layer (validate request, reply).  |
// | Option macro MAPLE_DEVINFO_EN adds the FUNC_CODE payload to the 05 reply.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module maple_responder #(
  parameter logic [7:0]  DEV_ADDR   = 8'h20,
  parameter int unsigned TURNAROUND = 16,
  parameter logic [31:0] FUNC_CODE  = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  maple_responder_if.slave bus
);
  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_RECV  = 3'd1;
  localparam logic [2:0]  S_CHECK = 3'd2;
  localparam logic [2:0]  S_TURN  = 3'd3;
  localparam logic [2:0]  S_SEND  = 3'd4;
  localparam logic [2:0]  S_DONE  = 3'd5;
  localparam logic [10:0] C_CNT_MAX = 11'h7FF;

  logic [2:0]  state_q, state_d;
  logic        rx_busy_q;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [7:0]  cmd_q, cmd_d, dest_q, dest_d, src_q, src_d, len_q, len_d;
  logic [15:0] turn_q, turn_d;
  logic [7:0]  rep_cmd_q, rep_cmd_d, rep_dst_q, rep_dst_d, rep_len_q, rep_len_d;
  logic [3:0]  last_idx_q, last_idx_d, idx_q, idx_d;
  logic [7:0]  txx_q, txx_d;
  logic        tx_enable_q, tx_enable_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ok_q, ok_d, err_q, err_d;
  logic [7:0]  last_cmd_q, last_cmd_d;

  logic        w_valid, w_long;
  logic [7:0]  w_rep_cmd, w_next_byte;
  logic [3:0]  w_nidx;

  assign w_valid = (byte_cnt_q == (11'd5 + {1'b0, len_q, 2'b00})) && (xor_q == 8'h00);
  assign w_rep_cmd = !w_valid           ? 8'hFC :
                     (cmd_q == 8'h01)   ? 8'h05 :
                     (cmd_q == 8'h03)   ? 8'h07 : 8'hFE;
`ifdef MAPLE_DEVINFO_EN
  assign w_long = w_valid && (cmd_q == 8'h01);
`else
  assign w_long = 1'b0;
  logic [31:0] unused_func_code;
  assign unused_func_code = FUNC_CODE;
`endif

  // Byte that follows the one currently on tx_data; the last slot carries the running XOR.
  assign w_nidx = idx_q + 4'd1;
  always_comb begin
    w_next_byte = 8'h00;
    if (w_nidx == last_idx_q) begin
      w_next_byte = txx_q ^ tx_data_q;
    end else begin
      case (w_nidx)
        4'd1:    w_next_byte = rep_dst_q;
        4'd2:    w_next_byte = DEV_ADDR;
        4'd3:    w_next_byte = rep_len_q;
`ifdef MAPLE_DEVINFO_EN
        4'd4:    w_next_byte = FUNC_CODE[31:24];
        4'd5:    w_next_byte = FUNC_CODE[23:16];
        4'd6:    w_next_byte = FUNC_CODE[15:8];
        4'd7:    w_next_byte = FUNC_CODE[7:0];
`endif
        default: w_next_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;  byte_cnt_d = byte_cnt_q;  xor_d = xor_q;
    cmd_d = cmd_q;  dest_d = dest_q;  src_d = src_q;  len_d = len_q;
    turn_d = turn_q;  rep_cmd_d = rep_cmd_q;  rep_dst_d = rep_dst_q;  rep_len_d = rep_len_q;
    last_idx_d = last_idx_q;  idx_d = idx_q;  txx_d = txx_q;
    tx_enable_d = tx_enable_q;  tx_data_d = tx_data_q;
    ok_d = 1'b0;  err_d = 1'b0;  last_cmd_d = last_cmd_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_busy && !rx_busy_q) begin
          state_d = S_RECV;  byte_cnt_d = 11'd0;  xor_d = 8'h00;
          cmd_d = 8'h00;  dest_d = 8'h00;  src_d = 8'h00;  len_d = 8'h00;
        end
      end
      S_RECV: begin
        if (bus.rx_write) begin
          case (byte_cnt_q)
            11'd0:   cmd_d  = bus.rx_data;
            11'd1:   dest_d = bus.rx_data;
            11'd2:   src_d  = bus.rx_data;
            11'd3:   len_d  = bus.rx_data;
            default: ;
          endcase
          xor_d = xor_q ^ bus.rx_data;
          if (byte_cnt_q != C_CNT_MAX) byte_cnt_d = byte_cnt_q + 11'd1;
        end
        if (!bus.rx_busy) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (dest_q != DEV_ADDR) begin
          state_d = S_IDLE;
        end else begin
          ok_d = w_valid;  err_d = !w_valid;  last_cmd_d = cmd_q;
          rep_cmd_d = w_rep_cmd;  rep_dst_d = src_q;  rep_len_d = {7'd0, w_long};
          last_idx_d = w_long ? 4'd8 : 4'd4;
          turn_d = 16'd1;
          // CHECK itself is the first turnaround cycle, so TURNAROUND of 1 skips TURN.
          if (TURNAROUND < 2) begin
            state_d = S_SEND;  tx_enable_d = 1'b1;  tx_data_d = w_rep_cmd;
            idx_d = 4'd0;  txx_d = 8'h00;
          end else begin
            state_d = S_TURN;
          end
        end
      end
      S_TURN: begin
        if (turn_q >= 16'(TURNAROUND - 1)) begin
          state_d = S_SEND;  tx_enable_d = 1'b1;  tx_data_d = rep_cmd_q;
          idx_d = 4'd0;  txx_d = 8'h00;
        end else begin
          turn_d = turn_q + 16'd1;
        end
      end
      S_SEND: begin
        if (bus.tx_next) begin
          txx_d = txx_q ^ tx_data_q;
          if (idx_q == last_idx_q) begin
            state_d = S_DONE;  tx_enable_d = 1'b0;
          end else begin
            idx_d = w_nidx;  tx_data_d = w_next_byte;
          end
        end
      end
      S_DONE: begin
        if (!bus.tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  rx_busy_q <= 1'b0;  byte_cnt_q <= 11'd0;  xor_q <= 8'h00;
      cmd_q <= 8'h00;  dest_q <= 8'h00;  src_q <= 8'h00;  len_q <= 8'h00;
      turn_q <= 16'd0;  rep_cmd_q <= 8'h00;  rep_dst_q <= 8'h00;  rep_len_q <= 8'h00;
      last_idx_q <= 4'd0;  idx_q <= 4'd0;  txx_q <= 8'h00;
      tx_enable_q <= 1'b0;  tx_data_q <= 8'h00;  ok_q <= 1'b0;  err_q <= 1'b0;
      last_cmd_q <= 8'h00;
    end else begin
      state_q <= state_d;  rx_busy_q <= bus.rx_busy;  byte_cnt_q <= byte_cnt_d;  xor_q <= xor_d;
      cmd_q <= cmd_d;  dest_q <= dest_d;  src_q <= src_d;  len_q <= len_d;
      turn_q <= turn_d;  rep_cmd_q <= rep_cmd_d;  rep_dst_q <= rep_dst_d;  rep_len_q <= rep_len_d;
      last_idx_q <= last_idx_d;  idx_q <= idx_d;  txx_q <= txx_d;
      tx_enable_q <= tx_enable_d;  tx_data_q <= tx_data_d;  ok_q <= ok_d;  err_q <= err_d;
      last_cmd_q <= last_cmd_d;
    end
  end

  assign bus.tx_enable = tx_enable_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.frame_ok  = ok_q;
  assign bus.frame_err = err_q;
  assign bus.last_cmd  = last_cmd_q;
endmodule
`default_nettype wire

// File: tb/tb_maple_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_maple_responder : directed + random request frames vs. a frame model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_maple_responder;
  localparam logic [7:0]  DEV_ADDR   = 8'h20;
  localparam int          TURNAROUND = 16;
  localparam logic [31:0] FUNC_CODE  = 32'h0000_0001;

  logic clk = 1'b0;
  logic reset;
  maple_responder_if bus();

  maple_responder #(.DEV_ADDR(DEV_ADDR), .TURNAROUND(TURNAROUND), .FUNC_CODE(FUNC_CODE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] req_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       exp_addr, exp_valid;
  logic [7:0] exp_last = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: reply computed straight from the frame rules on the whole request.
  task automatic model_frame();
    logic [7:0] cmd, dst, src, len, x, rc;
    int n;
    n   = req_q.size();
    cmd = (n > 0) ? req_q[0] : 8'h00;
    dst = (n > 1) ? req_q[1] : 8'h00;
    src = (n > 2) ? req_q[2] : 8'h00;
    len = (n > 3) ? req_q[3] : 8'h00;
    x = 8'h00;
    foreach (req_q[i]) x ^= req_q[i];
    exp_addr  = (dst == DEV_ADDR);
    exp_valid = (n == 5 + 4 * int'(len)) && (x == 8'h00);
    exp_q.delete();
    if (!exp_addr) return;
    exp_last = cmd;
    if (!exp_valid)         rc = 8'hFC;
    else if (cmd == 8'h01)  rc = 8'h05;
    else if (cmd == 8'h03)  rc = 8'h07;
    else                    rc = 8'hFE;
    exp_q.push_back(rc);
    exp_q.push_back(src);
    exp_q.push_back(DEV_ADDR);
`ifdef MAPLE_DEVINFO_EN
    if (exp_valid && cmd == 8'h01) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(FUNC_CODE[31:24]);
      exp_q.push_back(FUNC_CODE[23:16]);
      exp_q.push_back(FUNC_CODE[15:8]);
      exp_q.push_back(FUNC_CODE[7:0]);
    end else exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h00);
`endif
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
  endtask

  task automatic set5(input logic [7:0] a, b, c, d, e);
    req_q.delete();
    req_q.push_back(a); req_q.push_back(b); req_q.push_back(c);
    req_q.push_back(d); req_q.push_back(e);
  endtask

  task automatic mk_frame(input logic [7:0] cmd, dst, src, len, input bit good);
    logic [7:0] x;
    req_q.delete();
    req_q.push_back(cmd); req_q.push_back(dst); req_q.push_back(src); req_q.push_back(len);
    for (int i = 0; i < 4 * int'(len); i++) req_q.push_back(8'($urandom));
    x = 8'h00;
    foreach (req_q[i]) x ^= req_q[i];
    req_q.push_back(good ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
  endtask

  // Drive req_q into the DUT, then play the transmitter and compare with the model.
  task automatic run_frame(input string name, input bit same_end, input bit disturb, input int abort_at);
    int first_en, n_ok, n_err;
    bit en, aborted;
    model_frame();
    bus.rx_busy = 1'b1;
    tick();
    for (int i = 0; i < req_q.size(); i++) begin
      repeat ($urandom_range(0, 2)) tick();
      bus.rx_write = 1'b1;
      bus.rx_data  = req_q[i];
      if (same_end && i == req_q.size() - 1) bus.rx_busy = 1'b0;
      tick();
      bus.rx_write = 1'b0;
    end
    if (bus.rx_busy) begin
      bus.rx_busy = 1'b0;
      tick();
    end
    first_en = 0; n_ok = 0; n_err = 0;
    for (int k = 1; k <= TURNAROUND + 6; k++) begin
      @(negedge clk);
      n_ok  += int'(bus.frame_ok);
      n_err += int'(bus.frame_err);
      if (bus.tx_enable) begin
        first_en = k;
        break;
      end
    end
    check({name, " frame_ok"},  n_ok,  (exp_addr && exp_valid) ? 1 : 0);
    check({name, " frame_err"}, n_err, (exp_addr && !exp_valid) ? 1 : 0);
    check({name, " last_cmd"},  bus.last_cmd, exp_last);
    if (!exp_addr) begin
      check({name, " no_tx_enable"}, first_en, 0);
      return;
    end
    check({name, " turnaround"}, first_en - 1, TURNAROUND);
    if (first_en == 0) return;
    got_q.delete();
    aborted = 1'b0;
    bus.tx_busy = 1'b1;
    for (int b = 0; b < 20; b++) begin
      got_q.push_back(bus.tx_data);
      if (got_q.size() == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.tx_busy = 1'b0;
        exp_last = 8'h00;
        @(negedge clk);
        check({name, " abort tx_enable"}, bus.tx_enable, 0);
        check({name, " abort tx_data"},   bus.tx_data, 0);
        check({name, " abort last_cmd"},  bus.last_cmd, 0);
        aborted = 1'b1;
        break;
      end
      bus.tx_next = 1'b1;
      tick();
      bus.tx_next = 1'b0;
      if (disturb && got_q.size() == 2) begin
        bus.rx_busy  = 1'b1;
        bus.rx_write = 1'b1;
        bus.rx_data  = 8'(DEV_ADDR);
      end
      @(negedge clk);
      en = bus.tx_enable;
      if (disturb && got_q.size() == 2) begin
        tick();
        bus.rx_busy  = 1'b0;
        bus.rx_write = 1'b0;
        @(negedge clk);
      end
      if (!en) break;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (aborted) begin
      repeat (2) tick();
      return;
    end
    check({name, " reply_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s byte%0d", name, i), got_q[i], exp_q[i]);
    repeat (2) tick();
    bus.tx_busy = 1'b0;
    repeat (2) tick();
    check({name, " last_cmd_after"}, bus.last_cmd, exp_last);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmds[4];
    logic [7:0] dst;
    int kind;
    cmds[0] = 8'h01; cmds[1] = 8'h03; cmds[2] = 8'h09; cmds[3] = 8'h00;
    reset = 1'b1;
    bus.rx_busy = 1'b0; bus.rx_write = 1'b0; bus.rx_data = 8'h00;
    bus.tx_busy = 1'b0; bus.tx_next = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset tx_enable", bus.tx_enable, 0);
    check("reset tx_data",   bus.tx_data, 0);
    check("reset frame_ok",  bus.frame_ok, 0);
    check("reset frame_err", bus.frame_err, 0);
    check("reset last_cmd",  bus.last_cmd, 0);
    tick();
    reset = 1'b0;
    tick();

    set5(8'h01, 8'h20, 8'h00, 8'h00, 8'h21); run_frame("req01", 1'b0, 1'b0, 0);
    set5(8'h03, 8'h20, 8'h00, 8'h00, 8'h23); run_frame("req03", 1'b0, 1'b1, 0);
    set5(8'h09, 8'h20, 8'h00, 8'h00, 8'h29); run_frame("req09", 1'b1, 1'b0, 0);
    set5(8'h01, 8'h20, 8'h00, 8'h00, 8'h22); run_frame("badxor", 1'b0, 1'b0, 0);
    set5(8'h01, 8'h20, 8'h00, 8'h01, 8'h20); run_frame("shortlen", 1'b0, 1'b0, 0);
    set5(8'h01, 8'h01, 8'h00, 8'h00, 8'h00); run_frame("otheraddr", 1'b0, 1'b0, 0);
    req_q.delete();                          run_frame("zerobyte", 1'b0, 1'b0, 0);
    set5(8'h03, 8'h20, 8'h05, 8'h00, 8'h26); run_frame("abort", 1'b0, 1'b0, 3);
    set5(8'h01, 8'h20, 8'h00, 8'h00, 8'h21); run_frame("after_abort", 1'b0, 1'b0, 0);

    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        1: mk_frame(cmds[$urandom_range(0, 3)], DEV_ADDR, 8'($urandom), 8'($urandom_range(0, 3)), 1'b0);
        2: begin
          mk_frame(cmds[$urandom_range(0, 3)], DEV_ADDR, 8'($urandom), 8'($urandom_range(1, 3)), 1'b1);
          if ($urandom_range(0, 1) == 1) req_q.insert(4, 8'h00);
          else begin
            req_q[req_q.size() - 1] = req_q[req_q.size() - 1] ^ req_q[4];
            req_q.delete(4);
          end
        end
        3: begin
          dst = 8'($urandom);
          if (dst == DEV_ADDR) dst = dst ^ 8'h80;
          mk_frame(cmds[$urandom_range(0, 3)], dst, 8'($urandom), 8'($urandom_range(0, 2)), 1'b1);
        end
        default: mk_frame(cmds[$urandom_range(0, 3)], DEV_ADDR, 8'($urandom), 8'($urandom_range(0, 3)), 1'b1);
      endcase
      run_frame($sformatf("rnd%0d", f), kind == 4, kind == 5, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
